// File: rtl/bitty_param_core.sv
// Parametrised multi-cycle Bitty core: IDLE -> LOAD_S -> EXEC -> WB per instruction,
// with a valid/ready instruction handshake, carry/zero flags and preload/debug register access.
module bitty_param_core #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       din,
  input  logic              ld_en,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              done,
  output logic              illegal,
  output logic              carry,
  output logic              zero
);

  localparam int         SH_W   = $clog2(DATA_W);
  localparam logic [3:0] NREG_L = 4'(NREG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] c;

  logic [1:0]        fmt;
  logic [2:0]        op;
  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [7:0]        imm8;
  logic              legal;
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // Register indices at or beyond NREG do not exist; the spare array slots stay at zero.
  function automatic logic in_range(input logic [2:0] idx);
    return ({1'b0, idx} < NREG_L);
  endfunction

  assign fmt  = ir[1:0];
  assign op   = ir[4:2];
  assign rx   = ir[15:13];
  assign ry   = ir[12:10];
  assign imm8 = ir[12:5];

  assign legal = ((fmt == 2'b00) || (fmt == 2'b01)) && in_range(rx) &&
                 ((fmt != 2'b00) || in_range(ry));

  assign instr_ready = (state == IDLE) && !reset;
  assign sum_ext     = {1'b0, s} + {1'b0, opb};

  // Second operand: register in R format, zero-extended immediate otherwise.
  always_comb begin
    opb = '0;
    if (fmt == 2'b01) begin
      opb = DATA_W'(imm8);
    end else begin
      opb = regs[ry];
    end
  end

  // ALU result and carry for the current instruction.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      3'd0: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      3'd1: begin
        alu_res   = s - opb;
        alu_carry = (s < opb);
      end
      3'd2: alu_res = s & opb;
      3'd3: alu_res = s | opb;
      3'd4: alu_res = s ^ opb;
      3'd5: alu_res = s << opb[SH_W-1:0];
      3'd6: alu_res = s >> opb[SH_W-1:0];
      3'd7: begin
        if (s == opb) begin
          alu_res = '0;
        end else if (s > opb) begin
          alu_res = DATA_W'(2'd1);
        end else begin
          alu_res = DATA_W'(2'd2);
        end
      end
      default: alu_res = '0;
    endcase
  end

  // Debug read port, zero for non-existent registers.
  always_comb begin
    dbg_data = '0;
    if (in_range(dbg_addr)) begin
      dbg_data = regs[dbg_addr];
    end else begin
      dbg_data = '0;
    end
  end

  // Next-state logic: IDLE waits for a valid instruction, the other states advance unconditionally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          state_nxt = LOAD_S;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD_S:  state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath registers, flags and retire pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ir      <= 16'h0000;
      s       <= '0;
      c       <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          // Preload and accept may coincide; LOAD_S then reads the preloaded value.
          if (ld_en && in_range(ld_addr)) begin
            regs[ld_addr] <= ld_data;
          end
          if (instr_valid) begin
            ir <= din;
          end
        end
        LOAD_S: s <= regs[rx];
        EXEC: begin
          if (legal) begin
            c     <= alu_res;
            carry <= alu_carry;
            zero  <= (alu_res == '0);
          end
        end
        WB: begin
          if (legal) begin
            regs[rx] <= c;
          end
          done    <= 1'b1;
          illegal <= !legal;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_param_core.sv
// Scoreboard bench for bitty_param_core: directed instructions push expected retire
// results; a negedge monitor pops and compares them whenever done is seen.
module tb_bitty_param_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] din;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        done, illegal, carry, zero;

  logic        instr_valid4, instr_ready4, ld_en4;
  logic [15:0] din4, ld_data4, dbg_data4;
  logic [2:0]  ld_addr4, dbg_addr4;
  logic        done4, illegal4, carry4, zero4;

  always #5 clk = ~clk;

  bitty_param_core #(.DATA_W(16), .NREG(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .din(din), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .done(done), .illegal(illegal),
    .carry(carry), .zero(zero)
  );

  bitty_param_core #(.DATA_W(16), .NREG(4)) dut4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid4), .instr_ready(instr_ready4),
    .din(din4), .ld_en(ld_en4), .ld_addr(ld_addr4), .ld_data(ld_data4),
    .dbg_addr(dbg_addr4), .dbg_data(dbg_data4), .done(done4), .illegal(illegal4),
    .carry(carry4), .zero(zero4)
  );

  typedef struct {
    string       name;
    logic [15:0] val;
    logic        ill;
    logic        cy;
    logic        zf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  int   issued = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input string name, input logic [15:0] val,
                              input logic ill, input logic cy, input logic zf);
    exp_t e;
    e.name = name; e.val = val; e.ill = ill; e.cy = cy; e.zf = zf; e.cyc = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready) n_acc <= n_acc + 1;
  end

  // Monitor: every retire must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
        check({mon_e.name, "_illegal"}, 64'(illegal), 64'(mon_e.ill));
        check({mon_e.name, "_carry"}, 64'(carry), 64'(mon_e.cy));
        check({mon_e.name, "_zero"}, 64'(zero), 64'(mon_e.zf));
        check({mon_e.name, "_result"}, 64'(dbg_data), 64'(mon_e.val));
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Present an instruction (optionally with a simultaneous preload); returns #1 after the accept edge.
  task automatic issue(input logic [15:0] w, input logic [2:0] rx, input int hold,
                       input bit push, input exp_t e,
                       input bit ldv, input logic [2:0] lda, input logic [15:0] ldd);
    int n;
    n = 0;
    din = w; dbg_addr = rx; instr_valid = 1'b1;
    ld_en = ldv; ld_addr = lda; ld_data = ldd;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({e.name, "_ready"}, 64'(instr_ready), 64'(1));
    if (push) begin
      e.cyc = cyc + 4;
      sb.push_back(e);
    end
    issued++;
    @(posedge clk); #1;
    ld_en = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({name, "_retired"}, 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic read_reg(input string name, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(name, 64'(dbg_data), 64'(exp));
  endtask

  logic [15:0] w4   [2];
  logic        ill4 [2];
  int          dn;
  int          k;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; din = 16'h0000;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0000; dbg_addr = 3'd0;
    instr_valid4 = 1'b0; din4 = 16'h0000; ld_en4 = 1'b0; ld_addr4 = 3'd0;
    ld_data4 = 16'h0000; dbg_addr4 = 3'd0;
    w4[0] = 16'hA000; ill4[0] = 1'b1;
    w4[1] = 16'h2C00; ill4[1] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(instr_ready), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    check("rst_zero", 64'(zero), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(instr_ready), 64'(1));
    for (int i = 0; i < 8; i++) read_reg("rst_reg", 3'(i), 16'h0000);
    @(posedge clk); #1;

    // NREG=4 instance: out-of-range preload ignored, rx=5 illegal, in-range R format legal.
    ld_en4 = 1'b1; ld_addr4 = 3'd5; ld_data4 = 16'h00AA;
    @(posedge clk); #1;
    ld_en4 = 1'b0;
    dbg_addr4 = 3'd5; #1;
    check("n4_dbg_oob", 64'(dbg_data4), 64'(0));
    dbg_addr4 = 3'd1; #1;
    check("n4_no_alias", 64'(dbg_data4), 64'(0));
    for (int t = 0; t < 2; t++) begin
      din4 = w4[t]; instr_valid4 = 1'b1;
      @(posedge clk); #1;
      instr_valid4 = 1'b0;
      k = 0;
      @(negedge clk);
      while (!done4 && k < 10) begin
        @(negedge clk);
        k++;
      end
      check("n4_done", 64'(done4), 64'(1));
      check("n4_illegal", 64'(illegal4), 64'(ill4[t]));
      @(posedge clk); #1;
    end

    // add R1,R2 with instr_valid held through the busy cycles
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    issue(16'h2800, 3'd1, 2, 1'b1, mk("add", 16'h0008, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("add");

    preload(3'd3, 16'h0000);
    preload(3'd4, 16'h0001);
    issue(16'h7004, 3'd3, 0, 1'b1, mk("sub", 16'hFFFF, 1'b0, 1'b1, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("sub");

    // or R5,#0x0F with a preload of R2 attempted during EXEC
    preload(3'd5, 16'h00F0);
    issue(16'hA1ED, 3'd5, 0, 1'b1, mk("ori", 16'h00FF, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'h1234;
    @(posedge clk); #1;
    ld_en = 1'b0;
    drain("ori");
    read_reg("ld_in_exec_ignored", 3'd2, 16'h0003);

    preload(3'd6, 16'h0010);
    preload(3'd7, 16'h0020);
    issue(16'hDC1C, 3'd6, 0, 1'b1, mk("cmp", 16'h0002, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("cmp");

    issue(16'h0000, 3'd0, 0, 1'b1, mk("add_zero", 16'h0000, 1'b0, 1'b0, 1'b1), 1'b0, 3'd0, 16'h0);
    drain("add_zero");

    issue(16'h2802, 3'd1, 0, 1'b1, mk("illegal_fmt", 16'h0008, 1'b1, 1'b0, 1'b1), 1'b0, 3'd0, 16'h0);
    drain("illegal_fmt");
    read_reg("ill_r2", 3'd2, 16'h0003);
    read_reg("ill_r3", 3'd3, 16'hFFFF);
    read_reg("ill_r6", 3'd6, 16'h0002);

    issue(16'h3FF1, 3'd1, 0, 1'b1, mk("xori", 16'h00F7, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("xori");
    issue(16'h7014, 3'd3, 0, 1'b1, mk("shl", 16'hFFFE, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("shl");
    issue(16'hA099, 3'd5, 0, 1'b1, mk("shri", 16'h000F, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("shri");
    preload(3'd6, 16'hFFFF);
    issue(16'hC021, 3'd6, 0, 1'b1, mk("add_wrap", 16'h0000, 1'b0, 1'b1, 1'b1), 1'b0, 3'd0, 16'h0);
    drain("add_wrap");
    // shift amount 0x11 uses only its low 4 bits
    issue(16'hE235, 3'd7, 0, 1'b1, mk("shl_mask", 16'h0040, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    drain("shl_mask");
    // preload R4 in the accept cycle; LOAD_S must see the new value
    issue(16'h9E09, 3'd4, 0, 1'b1, mk("andi_preload", 16'h0030, 1'b0, 1'b0, 1'b0), 1'b1, 3'd4, 16'h0F3C);
    drain("andi_preload");

    // Reset during EXEC aborts add R1,R2
    preload(3'd1, 16'h0005);
    issue(16'h2800, 3'd1, 0, 1'b0, mk("abort", 16'h0000, 1'b0, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_in_reset", 64'(instr_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 64'(instr_ready), 64'(1));
    check("abort_r1", 64'(dbg_data), 64'(0));
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'(0));

    check("accept_count", 64'(n_acc), 64'(issued));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
